fifo_word_packer: RTL and testbench

Downstream consumer of the request byte FIFO in the DRAM cache front end. It pops DATA_WIDTH-bit entries from the FIFO's read port and assembles BEATS consecutive entries, little-endian, into one request word. The word is presented to the cache controller over a valid/ready handshake. A flush input aborts a partially assembled word, and a saturating counter records how many partial words were discarded.

---
 rtl/fifo_word_packer_if.sv | 33 +++
 rtl/fifo_word_packer.sv | 98 +++++++++
 tb/tb_fifo_word_packer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_packer_if.sv
// Bus between the request byte FIFO read port, the word packer and the
// cache controller. Holds the FIFO pop side and the output word handshake.
interface fifo_word_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BEATS      = 4
);
    logic                         fifo_empty_i;
    logic [DATA_WIDTH-1:0]        fifo_read_data_i;
    logic                         fifo_read_en_o;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [DATA_WIDTH*BEATS-1:0]  out_data_o;

    // Packer side: pops the FIFO and sources the assembled word.
    modport master (
        input  fifo_empty_i,
        input  fifo_read_data_i,
        input  out_ready_i,
        output fifo_read_en_o,
        output out_valid_o,
        output out_data_o
    );

    // Environment side: FIFO read port plus the word consumer.
    modport slave (
        output fifo_empty_i,
        output fifo_read_data_i,
        output out_ready_i,
        input  fifo_read_en_o,
        input  out_valid_o,
        input  out_data_o
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops DATA_WIDTH-bit entries from the request byte FIFO and packs BEATS of
// them little-endian into one word for the cache controller. A flush drops a
// partial word and bumps a saturating drop counter.
//
// Output handshake: out_valid_o stays high with out_data_o stable until a
// cycle where out_ready_i is also high; that cycle is the transfer. A final
// pop in the transfer cycle loads the next word, keeping valid high.
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int BEATS      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    fifo_word_packer_if.master           bus,
    input  logic                         flush_i,
    output logic [$clog2(BEATS+1)-1:0]   beat_cnt_o,
    output logic [7:0]                   drop_cnt_o
);
    localparam int CW = $clog2(BEATS + 1);
    localparam int AW = (BEATS - 1) * DATA_WIDTH;
    localparam int OW = BEATS * DATA_WIDTH;

    logic [AW-1:0] asm_q, asm_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [OW-1:0] out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    drop_q, drop_d;

    logic slot_free;
    logic last_beat;
    logic pop;
    logic xfer;

    // Pop decision and next-state for assembly, output slot and drop counter.
    always_comb begin
        asm_d       = asm_q;
        beat_d      = beat_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        drop_d      = drop_q;

        slot_free = !out_valid_q || bus.out_ready_i;
        last_beat = (beat_q == CW'(BEATS - 1));
        xfer      = out_valid_q && bus.out_ready_i;
        // The last entry may only be taken when the output slot can accept it.
        pop = rst_n && !bus.fifo_empty_i && !flush_i && (!last_beat || slot_free);

        if (xfer) begin
            out_valid_d = 1'b0;
        end

        if (pop && !last_beat) begin
            for (int i = 0; i < BEATS - 1; i++) begin
                if (beat_q == CW'(i)) begin
                    asm_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_read_data_i;
                end
            end
            beat_d = beat_q + CW'(1);
        end else if (pop && last_beat) begin
            // Stale asm_q bits are left in place; every slot is rewritten
            // before the next final pop reads it.
            out_d       = {bus.fifo_read_data_i, asm_q};
            out_valid_d = 1'b1;
            beat_d      = '0;
        end

        // Flush only touches the assembly side; the output slot is untouched.
        if (flush_i) begin
            beat_d = '0;
            if (beat_q != '0 && drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_q       <= '0;
            beat_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            asm_q       <= asm_d;
            beat_q      <= beat_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.fifo_read_en_o = pop;
    assign bus.out_valid_o    = out_valid_q;
    assign bus.out_data_o     = out_q;
    assign beat_cnt_o         = beat_q;
    assign drop_cnt_o         = drop_q;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: a behavioural byte FIFO feeds the DUT,
// a monitor logs pops and word transfers, and hand-computed values are
// compared through check_eq.
module tb_fifo_word_packer;
    localparam int DW = 8;
    localparam int NB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush_i;
    logic       out_ready;
    logic [2:0] beat_cnt;
    logic [7:0] drop_cnt;

    fifo_word_packer_if #(.DATA_WIDTH(DW), .BEATS(NB)) bus ();

    fifo_word_packer #(.DATA_WIDTH(DW), .BEATS(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush_i    (flush_i),
        .beat_cnt_o (beat_cnt),
        .drop_cnt_o (drop_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural FIFO ----------------
    logic [7:0] mem [0:511];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc    = 0;

    assign bus.fifo_empty_i     = (rd_ptr == wr_ptr);
    assign bus.fifo_read_data_i = mem[rd_ptr[8:0]];
    assign bus.out_ready_i      = out_ready;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_read_en_o) rd_ptr <= rd_ptr + 1;
    end

    // ---------------- monitor (samples mid low phase) ----------------
    int          n_pop  = 0;
    int          n_xfer = 0;
    logic [31:0] got_word [0:63];
    int          got_cyc  [0:63];

    always begin
        @(negedge clk);
        #3;
        if (rst_n && bus.fifo_read_en_o) n_pop = n_pop + 1;
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            if (n_xfer < 64) begin
                got_word[n_xfer] = bus.out_data_o;
                got_cyc[n_xfer]  = cyc;
            end
            n_xfer = n_xfer + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push(input logic [7:0] b);
        mem[wr_ptr[8:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_valid(input int max_cyc, output int n);
        n = 0;
        while (!bus.out_valid_o && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) check_eq("valid_timeout", 32'(n), 32'(max_cyc - 1));
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int n, p0, x0;

    initial begin
        rst_n     = 1'b0;
        flush_i   = 1'b0;
        out_ready = 1'b1;
        cyc_n(3);

        // Test 1: reset state, then a single word with ready held high.
        for (int i = 1; i <= 4; i++) push(8'(i * 8'h11));
        @(negedge clk);
        check_eq("rst_read_en", 32'(bus.fifo_read_en_o), 32'h0);
        check_eq("rst_valid",   32'(bus.out_valid_o),    32'h0);
        check_eq("rst_data",    bus.out_data_o,          32'h0);
        check_eq("rst_beat",    32'(beat_cnt),           32'h0);
        check_eq("rst_drop",    32'(drop_cnt),           32'h0);
        p0 = n_pop;
        rst_n = 1'b1;
        wait_valid(20, n);
        check_eq("t1_latency", 32'(n), 32'd4);
        check_eq("t1_data",    bus.out_data_o, 32'h44332211);
        check_eq("t1_beat",    32'(beat_cnt), 32'h0);
        check_eq("t1_pops",    32'(n_pop - p0), 32'd4);
        @(negedge clk);
        check_eq("t1_valid_drop", 32'(bus.out_valid_o), 32'h0);
        check_eq("t1_xfers",      32'(n_xfer), 32'd1);
        check_eq("t1_word",       got_word[0], 32'h44332211);

        // Test 2: backpressure, stall at BEATS-1, then back-to-back reload.
        out_ready = 1'b0;
        p0 = n_pop;
        x0 = n_xfer;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_valid(20, n);
        check_eq("t2_latency", 32'(n), 32'd4);
        check_eq("t2_data",    bus.out_data_o, 32'h04030201);
        cyc_n(5);
        check_eq("t2_hold_data",  bus.out_data_o, 32'h04030201);
        check_eq("t2_hold_valid", 32'(bus.out_valid_o), 32'h1);
        check_eq("t2_stall_beat", 32'(beat_cnt), 32'd3);
        check_eq("t2_stall_pop",  32'(bus.fifo_read_en_o), 32'h0);
        check_eq("t2_pops",       32'(n_pop - p0), 32'd7);
        out_ready = 1'b1;
        #1;
        check_eq("t2_release_pop", 32'(bus.fifo_read_en_o), 32'h1);
        @(negedge clk);
        check_eq("t2_b2b_valid", 32'(bus.out_valid_o), 32'h1);
        check_eq("t2_b2b_data",  bus.out_data_o, 32'h08070605);
        check_eq("t2_b2b_beat",  32'(beat_cnt), 32'h0);
        check_eq("t2_first_word", got_word[x0], 32'h04030201);
        @(negedge clk);
        check_eq("t2_end_valid", 32'(bus.out_valid_o), 32'h0);
        check_eq("t2_xfers",     32'(n_xfer - x0), 32'd2);
        check_eq("t2_second_word", got_word[x0+1], 32'h08070605);

        // Test 3: streaming, 12 entries -> 3 words exactly 4 cycles apart.
        p0 = n_pop;
        x0 = n_xfer;
        for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
        cyc_n(14);
        check_eq("t3_pops",  32'(n_pop - p0), 32'd12);
        check_eq("t3_xfers", 32'(n_xfer - x0), 32'd3);
        check_eq("t3_w0", got_word[x0],   32'h13121110);
        check_eq("t3_w1", got_word[x0+1], 32'h17161514);
        check_eq("t3_w2", got_word[x0+2], 32'h1B1A1918);
        check_eq("t3_gap0", 32'(got_cyc[x0+1] - got_cyc[x0]),   32'd4);
        check_eq("t3_gap1", 32'(got_cyc[x0+2] - got_cyc[x0+1]), 32'd4);

        // Test 4: flush of a partial word, flush when empty, flush vs final pop.
        push(8'hAA);
        push(8'hBB);
        cyc_n(2);
        check_eq("t4_beat_pre", 32'(beat_cnt), 32'd2);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("t4_drop1", 32'(drop_cnt), 32'd1);
        check_eq("t4_beat0", 32'(beat_cnt), 32'd0);
        for (int i = 1; i <= 4; i++) push(8'(i));
        wait_valid(20, n);
        check_eq("t4_word", bus.out_data_o, 32'h04030201);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("t4_idle_flush_drop", 32'(drop_cnt), 32'd1);
        for (int i = 1; i <= 3; i++) push(8'(8'h30 + i));
        cyc_n(3);
        check_eq("t4_beat3", 32'(beat_cnt), 32'd3);
        push(8'h34);
        flush_i = 1'b1;
        #1;
        check_eq("t4_flush_blocks_pop", 32'(bus.fifo_read_en_o), 32'h0);
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("t4_fp_beat",  32'(beat_cnt), 32'd0);
        check_eq("t4_fp_drop",  32'(drop_cnt), 32'd2);
        check_eq("t4_fp_valid", 32'(bus.out_valid_o), 32'h0);
        @(negedge clk);
        check_eq("t4_left_entry_beat", 32'(beat_cnt), 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("t4_drop3", 32'(drop_cnt), 32'd3);

        // Test 5: drop counter saturation.
        for (int i = 0; i < 256; i++) begin
            push(8'(i));
            @(negedge clk);
            flush_i = 1'b1;
            @(negedge clk);
            flush_i = 1'b0;
        end
        check_eq("t5_drop_sat", 32'(drop_cnt), 32'd255);
        push(8'h5F);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("t5_drop_hold", 32'(drop_cnt), 32'd255);
        check_eq("t5_beat",      32'(beat_cnt), 32'd0);

        // Test 6: reset mid-word with a pending output word.
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(8'(8'h60 + i));
        cyc_n(6);
        check_eq("t6_pre_valid", 32'(bus.out_valid_o), 32'h1);
        check_eq("t6_pre_beat",  32'(beat_cnt), 32'd2);
        check_eq("t6_pre_data",  bus.out_data_o, 32'h64636261);
        x0 = n_xfer;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6_rst_valid",   32'(bus.out_valid_o), 32'h0);
        check_eq("t6_rst_data",    bus.out_data_o, 32'h0);
        check_eq("t6_rst_beat",    32'(beat_cnt), 32'h0);
        check_eq("t6_rst_drop",    32'(drop_cnt), 32'h0);
        check_eq("t6_rst_read_en", 32'(bus.fifo_read_en_o), 32'h0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(8'(8'h70 + i));
        wait_valid(20, n);
        check_eq("t6_latency", 32'(n), 32'd4);
        check_eq("t6_data",    bus.out_data_o, 32'h74737271);
        @(negedge clk);
        check_eq("t6_xfers", 32'(n_xfer - x0), 32'd1);
        check_eq("t6_word",  got_word[x0], 32'h74737271);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
